uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Command-frame sequencer between `uart_rx` and the correlator's control-register file. It detects completed bytes from the receiver, assembles header/payload frames, and issues single-cycle register write or read strobes with address and data. It also enforces an inter-byte timeout and, optionally, a frame checksum, so a truncated or corrupt host frame never reaches the registers.

## Interface
- `WORD_WIDTH`, 8, byte width delivered by `uart_rx`; fixed at 8, other values unsupported.
- `ADDR_WIDTH`, 4, register address width, 1..6.
- `DATA_BYTES`, 4, payload bytes per write frame, 1..8.
- `TIMEOUT`, 1023, maximum clocks allowed between byte strobes inside a frame, ≥2.

- `clk`  in  1  system clock, same clock as `uart_rx`.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  WORD_WIDTH  `uart_rx.dout`.
- `rx_done`  in  1  `uart_rx.rx_done`: level, high while the receiver is idle.
- `reg_addr`  out  ADDR_WIDTH  target register address.
- `reg_wdata`  out  8*DATA_BYTES  write payload.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `busy`  out  1  high while a frame is in progress.
- `frame_err`  out  1  one-cycle pulse on timeout or checksum failure.

## Operation
- Byte strobe `stb` = `rx_done & ~rx_done_q`, where `rx_done_q` is a register of `rx_done` that resets to 1. No strobe is generated for the idle-high level present at reset release.
- Header byte: bit7 = 1 (sync), bit6 = 1 for write or 0 for read, bits[ADDR_WIDTH-1:0] = address. Bits between ADDR_WIDTH and 5 are ignored.
- IDLE:
  - Strobe with bit7 = 0: byte discarded, no error.
  - Header with bit6 = 0 (read): latch address, pulse `reg_re`, remain in IDLE. With `UART_CMD_CHECKSUM_EN`, go to CSUM instead.
  - Header with bit6 = 1 (write): latch address, clear the payload shift register and byte counter, go to DATA.
- DATA:
  - Each strobe shifts the byte in MSB-first: `wdata_sr <= {wdata_sr, byte}`. All 8 bits are raw payload; no sync check.
  - After the `DATA_BYTES`-th byte, go to CSUM if the macro is defined. Otherwise commit: copy the shift register to `reg_wdata`, pulse `reg_we`, return to IDLE.
- CSUM (macro only): the received byte is compared against the running XOR of header and payload bytes.
  - Match: commit, pulsing `reg_we` for a write or `reg_re` for a read.
  - Mismatch: pulse `frame_err` and return to IDLE without committing.
- Timeout:
  - Counter clears on every strobe and counts every clock while in DATA or CSUM.
  - On reaching `TIMEOUT`: pulse `frame_err`, return to IDLE, discard the partial frame.
  - A strobe in the same cycle as the terminal count wins: the byte is accepted and the counter clears.
- `reg_addr` and `reg_wdata` are updated only at commit (`reg_addr` also at read issue) and hold otherwise. Registers never see partial payloads.
- `busy` = state ≠ IDLE, registered.

## Timing
- Reset values: `reg_addr` = 0, `reg_wdata` = 0, `reg_we` = 0, `reg_re` = 0, `busy` = 0, `frame_err` = 0, state IDLE, `rx_done_q` = 1, counters 0.
- A strobe is sampled on the edge where `rx_done` = 1 and `rx_done_q` = 0.
- `reg_we`, `reg_re`, and `frame_err` go high in the cycle immediately after the decisive edge, for exactly one cycle.
- `reg_addr` and `reg_wdata` are valid in the same cycle as their strobe.
- A timeout error pulse occurs `TIMEOUT` clocks after the last strobe, ±1.
- Reset assertion mid-frame aborts immediately, with no strobe and no error pulse.
- Back-to-back frames need no gap: a header strobe in the cycle after a commit is accepted.

## Configuration
- `UART_CMD_CHECKSUM_EN`
  - Defined: every frame, read or write, ends with one XOR checksum byte (XOR of the header and all payload bytes). The CSUM state and XOR accumulator exist.
  - Undefined: no checksum byte is expected; the CSUM state and accumulator are not synthesized.

## Test plan
- Write 0xC3, 0x12, 0x34, 0x56, 0x78 (no macro) -> one `reg_we` pulse with `reg_addr` = 3 and `reg_wdata` = 0x12345678; `frame_err` stays 0.
- Read 0x85 -> one `reg_re` pulse with `reg_addr` = 5; `reg_wdata` unchanged; `busy` never asserts.
- Stray 0x41 in IDLE, then 0xC1 and four 0xFF bytes -> 0x41 ignored; `reg_wdata` = 0xFFFFFFFF, `reg_addr` = 1; the 0xFF payload bytes are not taken as headers.
- Header 0xC2 plus two payload bytes, then silence for 1100 clocks -> `frame_err` pulse about 1023 clocks after the last strobe, no `reg_we`, `busy` drops to 0.
- Macro defined: 0xC0, 0x01, 0x02, 0x03, 0x04 with checksum 0xC4 -> `reg_we` asserted; the same frame with checksum 0x00 -> `frame_err` pulse, no `reg_we`, `reg_wdata` unchanged.
- `rst_n` pulsed low after 0xC7 and one payload byte -> all outputs return to reset values; a following complete frame commits normally.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_decoder
// Brief   : Turns uart_rx bytes into header/payload register frames and issues
//           one-cycle write/read strobes; inter-byte timeout aborts a frame.
//           Define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte.
// Revision: 1.0 - initial release
// ============================================================================
module uart_cmd_decoder #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WORD_WIDTH-1:0]   rx_data,
  input  logic                    rx_done,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_we,
  output logic                    reg_re,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int c_cnt_w = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int c_tmo_w = $clog2(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(DATA_BYTES - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last  = c_tmo_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CSUM} state_t;

  state_t                    r_state;
  logic                      r_rx_done_q;
  logic [ADDR_WIDTH-1:0]     r_addr_lat;
  logic [8*DATA_BYTES-1:0]   r_wdata_sr;
  logic [c_cnt_w-1:0]        r_byte_cnt;
  logic [c_tmo_w-1:0]        r_tmo_cnt;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]                r_csum;
  logic                      r_is_write;
`endif

  logic                      w_stb;
  logic [8*DATA_BYTES+7:0]   w_sr_ext;
  logic [8*DATA_BYTES-1:0]   w_sr_next;

  // Rising edge of the idle-high rx_done level marks a completed byte.
  assign w_stb     = rx_done & ~r_rx_done_q;
  assign w_sr_ext  = {r_wdata_sr, rx_data};
  assign w_sr_next = w_sr_ext[8*DATA_BYTES-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rx_done_q <= 1'b1;
      r_addr_lat  <= '0;
      r_wdata_sr  <= '0;
      r_byte_cnt  <= '0;
      r_tmo_cnt   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      r_csum      <= '0;
      r_is_write  <= 1'b0;
`endif
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_rx_done_q <= rx_done;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      frame_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tmo_cnt <= '0;
          if (w_stb && rx_data[7]) begin
            r_addr_lat <= rx_data[ADDR_WIDTH-1:0];
`ifdef UART_CMD_CHECKSUM_EN
            r_csum     <= rx_data;
            r_is_write <= rx_data[6];
`endif
            if (rx_data[6]) begin
              r_wdata_sr <= '0;
              r_byte_cnt <= '0;
              r_state    <= S_DATA;
              busy       <= 1'b1;
            end else begin
`ifdef UART_CMD_CHECKSUM_EN
              r_state    <= S_CSUM;
              busy       <= 1'b1;
`else
              reg_addr   <= rx_data[ADDR_WIDTH-1:0];
              reg_re     <= 1'b1;
`endif
            end
          end
        end
        S_DATA: begin
          if (w_stb) begin
            r_tmo_cnt  <= '0;
            r_wdata_sr <= w_sr_next;
            r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
            r_csum     <= r_csum ^ rx_data;
            if (r_byte_cnt == c_last_byte) r_state <= S_CSUM;
`else
            if (r_byte_cnt == c_last_byte) begin
              reg_wdata <= w_sr_next;
              reg_addr  <= r_addr_lat;
              reg_we    <= 1'b1;
              r_state   <= S_IDLE;
              busy      <= 1'b0;
            end
`endif
          end else if (r_tmo_cnt == c_tmo_last) begin
            frame_err <= 1'b1;
            r_state   <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        default: begin
`ifdef UART_CMD_CHECKSUM_EN
          if (w_stb) begin
            r_tmo_cnt <= '0;
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            if (rx_data == r_csum) begin
              reg_addr <= r_addr_lat;
              if (r_is_write) begin
                reg_wdata <= r_wdata_sr;
                reg_we    <= 1'b1;
              end else begin
                reg_re    <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else if (r_tmo_cnt == c_tmo_last) begin
            frame_err <= 1'b1;
            r_state   <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`else
          r_state <= S_IDLE;
          busy    <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_cmd_decoder
// Brief   : Directed self-checking bench for uart_cmd_decoder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic        busy;
  logic        frame_err;

  int tests_run = 0;
  int tests_failed = 0;

  // Monitor totals; steps compare deltas against snapshots.
  int          we_tot = 0, re_tot = 0, err_tot = 0, busy_tot = 0;
  logic [3:0]  we_addr = '0, re_addr = '0;
  logic [31:0] we_data = '0;

  uart_cmd_decoder #(
    .WORD_WIDTH(8), .ADDR_WIDTH(4), .DATA_BYTES(4), .TIMEOUT(1023)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .busy(busy), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_we) begin
      we_tot  <= we_tot + 1;
      we_addr <= reg_addr;
      we_data <= reg_wdata;
    end
    if (reg_re) begin
      re_tot  <= re_tot + 1;
      re_addr <= reg_addr;
    end
    if (frame_err) err_tot  <= err_tot + 1;
    if (busy)      busy_tot <= busy_tot + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Sends a frame, appending the XOR checksum when the checksum build is used.
  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] pay, input int n);
    logic [7:0] x;
    x = hdr;
    send_byte(hdr);
    for (int i = 0; i < n; i++) begin
      send_byte(pay[31-8*i -: 8]);
      x = x ^ pay[31-8*i -: 8];
    end
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  int we0, re0, err0, busy0, n;
  logic seen;

  initial begin
    rst_n   = 1'b0;
    rx_done = 1'b1;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr",  reg_addr,  0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_we",    reg_we,    0);
    check("rst_re",    reg_re,    0);
    check("rst_busy",  busy,      0);
    check("rst_err",   frame_err, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_strobe_at_release", busy, 0);

    // Write frame to address 3
    we0 = we_tot; err0 = err_tot;
    send_byte(8'hC3);
    check("busy_in_frame", busy, 1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'hCB);
`endif
    check("wr_we_cnt", we_tot - we0, 1);
    check("wr_addr",   we_addr, 4'h3);
    check("wr_data",   we_data, 32'h12345678);
    check("wr_no_err", err_tot - err0, 0);
    check("wr_busy_low", busy, 0);

    // Read from address 5
    we0 = we_tot; re0 = re_tot; busy0 = busy_tot;
    send_frame(8'h85, 32'h0, 0);
    check("rd_re_cnt", re_tot - re0, 1);
    check("rd_addr",   re_addr, 4'h5);
    check("rd_wdata_held", reg_wdata, 32'h12345678);
    check("rd_no_we",  we_tot - we0, 0);
`ifndef UART_CMD_CHECKSUM_EN
    check("rd_no_busy", busy_tot - busy0, 0);
`endif

    // Stray non-sync byte, then payload of all ones
    we0 = we_tot; re0 = re_tot; err0 = err_tot;
    send_byte(8'h41);
    check("stray_ignored", busy, 0);
    send_frame(8'hC1, 32'hFFFFFFFF, 4);
    check("ff_we_cnt", we_tot - we0, 1);
    check("ff_addr",   we_addr, 4'h1);
    check("ff_data",   we_data, 32'hFFFFFFFF);
    check("ff_no_re",  re_tot - re0, 0);
    check("ff_no_err", err_tot - err0, 0);

    // Truncated frame: timeout ~1023 clocks after last strobe
    we0 = we_tot; err0 = err_tot;
    send_byte(8'hC2); send_byte(8'hAA); send_byte(8'hBB);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (frame_err) begin seen = 1'b1; break; end
      n++;
    end
    check("tmo_seen",   seen, 1);
    check("tmo_window", (n >= 1018 && n <= 1024), 1);
    repeat (5) @(posedge clk);
    #1;
    check("tmo_one_pulse", err_tot - err0, 1);
    check("tmo_no_we",     we_tot - we0, 0);
    check("tmo_busy_low",  busy, 0);
    check("tmo_wdata_held", reg_wdata, 32'hFFFFFFFF);

`ifdef UART_CMD_CHECKSUM_EN
    we0 = we_tot; err0 = err_tot;
    send_byte(8'hC0); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'hC4);
    check("cs_good_we",   we_tot - we0, 1);
    check("cs_good_data", we_data, 32'h01020304);
    we0 = we_tot;
    send_byte(8'hC0); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h00);
    check("cs_bad_err",   err_tot - err0, 1);
    check("cs_bad_no_we", we_tot - we0, 0);
    check("cs_bad_wdata", reg_wdata, 32'h01020304);
`endif

    // Reset mid-frame, then a complete frame
    send_byte(8'hC7); send_byte(8'h11);
    err0 = err_tot;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_addr",  reg_addr, 0);
    check("mid_rst_wdata", reg_wdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    we0 = we_tot;
    send_frame(8'hC7, 32'hAABBCCDD, 4);
    check("post_rst_we",   we_tot - we0, 1);
    check("post_rst_addr", we_addr, 4'h7);
    check("post_rst_data", we_data, 32'hAABBCCDD);
    check("post_rst_no_err", err_tot - err0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
